// File: rtl/fetch_queue_stage_if.sv
// Fetch-stage bus bundle: instruction-memory read port plus the
// valid/ready instruction handshake toward decode.
interface fetch_queue_stage_if #(
    parameter int IWIDTH = 24,
    parameter int PWIDTH = 16
);
    logic              imem_req;
    logic [PWIDTH-1:0] imem_addr;
    logic [IWIDTH-1:0] imem_rdata;
    logic              instr_valid;
    logic              instr_ready;
    logic [IWIDTH-1:0] instr;
    logic [PWIDTH-1:0] instr_pc;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        output instr_valid,
        input  instr_ready,
        output instr,
        output instr_pc
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  instr_pc
    );
endinterface

// File: rtl/fetch_queue_stage.sv
// Instruction fetch stage: PC register, 1-cycle imem read, DEPTH-entry queue.
// Define FETCH_PERF_EN to add the saturating decode-stall counter port.
module fetch_queue_stage #(
    parameter int          IWIDTH   = 24,
    parameter int          PWIDTH   = 16,
    parameter int          DEPTH    = 4,
    parameter int          STEP     = 1,
    parameter logic [PWIDTH-1:0] RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              redirect_i,
    input  logic [PWIDTH-1:0] redirect_pc_i,
`ifdef FETCH_PERF_EN
    output logic [31:0]       perf_stall_cnt_o,
`endif
    fetch_queue_stage_if.master fq
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW:0]   DEPTH_OCC = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [PWIDTH-1:0] STEP_W = PWIDTH'(STEP);

    typedef struct packed {
        logic [IWIDTH-1:0] instr;
        logic [PWIDTH-1:0] pc;
    } entry_t;

    logic [PWIDTH-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [PWIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic [CW-1:0]     count_q, count_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    entry_t            mem_q [DEPTH];
    entry_t            mem_d [DEPTH];

    logic        valid;
    logic        pop;
    logic        push;
    logic        issue;
    logic [CW:0] occ;
    entry_t      head;

    // Outputs are masked during reset so nothing partial leaks out.
    always_comb begin
        valid = (count_q != '0) & ~rst_i;
        pop   = valid & fq.instr_ready;
        occ   = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
        issue = ~rst_i & ~redirect_i & (occ < DEPTH_OCC);
        push  = inflight_q & ~redirect_i & ~rst_i;
        head  = mem_q[rd_ptr_q];
    end

    assign fq.imem_req    = issue;
    assign fq.imem_addr   = pc_q;
    assign fq.instr_valid = valid;
    assign fq.instr       = valid ? head.instr : '0;
    assign fq.instr_pc    = valid ? head.pc : '0;

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        mem_d         = mem_q;
        if (redirect_i) begin
            pc_d     = redirect_pc_i;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (issue) begin
                pc_d          = pc_q + STEP_W;
                inflight_pc_d = pc_q;
            end
            if (push) begin
                mem_d[wr_ptr_q] = '{instr: fq.imem_rdata, pc: inflight_pc_q};
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // Queue storage carries no reset; validity lives in count_q.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(push && count_q == DEPTH_CNT));
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (valid && !fq.instr_ready && perf_q != 32'hFFFF_FFFF) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_stall_cnt_o = perf_q;
`endif

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage: startup, back-pressure, redirect,
// PC wrap, reset priority and (with FETCH_PERF_EN) the stall counter.
module tb_fetch_queue_stage;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [15:0] redirect_pc;
    int          n_cmp;
    int          n_bad;
    int          nreq;
`ifdef FETCH_PERF_EN
    logic [31:0] perf;
`endif

    fetch_queue_stage_if #(.IWIDTH(24), .PWIDTH(16)) fq ();

    fetch_queue_stage #(
        .IWIDTH   (24),
        .PWIDTH   (16),
        .DEPTH    (4),
        .STEP     (1),
        .RESET_PC (16'h0010)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .redirect_i       (redirect),
        .redirect_pc_i    (redirect_pc),
`ifdef FETCH_PERF_EN
        .perf_stall_cnt_o (perf),
`endif
        .fq               (fq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: registered read, data = address.
    always @(posedge clk) begin
        if (fq.imem_req) fq.imem_rdata <= {8'h00, fq.imem_addr};
        else             fq.imem_rdata <= 24'hBAD000;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns in cycle 0, the first cycle with rst low.
    task automatic do_reset(input logic rdy);
        rst = 1'b1;
        redirect = 1'b0;
        fq.instr_ready = rdy;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        redirect = 1'b0;
        redirect_pc = '0;
        fq.instr_ready = 1'b1;

        // Reset state
        step();
        #1;
        check_eq("rst_valid", 32'(fq.instr_valid), 32'h0);
        check_eq("rst_req", 32'(fq.imem_req), 32'h0);
        check_eq("rst_instr", 32'(fq.instr), 32'h0);
        check_eq("rst_pc", 32'(fq.instr_pc), 32'h0);
        step();
        #1;
        check_eq("rst_addr", 32'(fq.imem_addr), 32'h10);
`ifdef FETCH_PERF_EN
        check_eq("rst_perf", perf, 32'h0);
`endif
        rst = 1'b0;
        #1;

        // Streaming with ready high, cycles 0..5
        for (int c = 0; c < 6; c++) begin
            if (c > 0) begin
                step();
                #1;
            end
            check_eq("stream_addr", 32'(fq.imem_addr), 32'h10 + 32'(c));
            check_eq("stream_req", 32'(fq.imem_req), 32'h1);
            check_eq("stream_valid", 32'(fq.instr_valid), (c >= 2) ? 32'h1 : 32'h0);
            if (c >= 2) begin
                check_eq("stream_pc", 32'(fq.instr_pc), 32'h10 + 32'(c - 2));
                check_eq("stream_instr", 32'(fq.instr), 32'h10 + 32'(c - 2));
            end
        end

        // Redirect in cycle 6 with an entry queued and a read in flight
        step();
        redirect = 1'b1;
        redirect_pc = 16'h0100;
        #1;
        check_eq("redir_req", 32'(fq.imem_req), 32'h0);
        check_eq("redir_had_entry", 32'(fq.instr_valid), 32'h1);
        step();
        redirect = 1'b0;
        #1;
        check_eq("redir_n1_valid", 32'(fq.instr_valid), 32'h0);
        check_eq("redir_n1_addr", 32'(fq.imem_addr), 32'h100);
        check_eq("redir_n1_req", 32'(fq.imem_req), 32'h1);
        step();
        #1;
        check_eq("redir_n2_valid", 32'(fq.instr_valid), 32'h0);
        check_eq("redir_n2_addr", 32'(fq.imem_addr), 32'h101);
        step();
        #1;
        check_eq("redir_n3_valid", 32'(fq.instr_valid), 32'h1);
        check_eq("redir_n3_pc", 32'(fq.instr_pc), 32'h100);
        check_eq("redir_n3_instr", 32'(fq.instr), 32'h100);
        step();
        #1;
        check_eq("redir_n4_pc", 32'(fq.instr_pc), 32'h101);

        // Back-to-back redirects: the second target wins
        step();
        redirect = 1'b1;
        redirect_pc = 16'h0300;
        #1;
        step();
        redirect_pc = 16'h0400;
        #1;
        step();
        redirect = 1'b0;
        #1;
        check_eq("b2b_addr", 32'(fq.imem_addr), 32'h400);
        step();
        #1;
        check_eq("b2b_gap_valid", 32'(fq.instr_valid), 32'h0);
        step();
        #1;
        check_eq("b2b_pc", 32'(fq.instr_pc), 32'h400);

        // Back-pressure from reset
        do_reset(1'b0);
        nreq = 0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) begin
                step();
                #1;
            end
            nreq += int'(fq.imem_req);
            if (c < 4) check_eq("bp_addr", 32'(fq.imem_addr), 32'h10 + 32'(c));
            else       check_eq("bp_noreq", 32'(fq.imem_req), 32'h0);
            if (c >= 2) check_eq("bp_head", 32'(fq.instr_pc), 32'h10);
        end
        check_eq("bp_nreq", 32'(nreq), 32'd4);
        step();
        fq.instr_ready = 1'b1;
        #1;
        check_eq("bp_resume_req", 32'(fq.imem_req), 32'h1);
        check_eq("bp_resume_addr", 32'(fq.imem_addr), 32'h14);
        check_eq("bp_drain0", 32'(fq.instr_pc), 32'h10);
        for (int d = 1; d < 5; d++) begin
            step();
            #1;
            check_eq("bp_drain_valid", 32'(fq.instr_valid), 32'h1);
            check_eq("bp_drain_pc", 32'(fq.instr_pc), 32'h10 + 32'(d));
        end

        // PC wrap across 0xFFFF
        do_reset(1'b1);
        redirect = 1'b1;
        redirect_pc = 16'hFFFE;
        #1;
        step();
        redirect = 1'b0;
        #1;
        check_eq("wrap_addr0", 32'(fq.imem_addr), 32'hFFFE);
        step();
        #1;
        check_eq("wrap_addr1", 32'(fq.imem_addr), 32'hFFFF);
        step();
        #1;
        check_eq("wrap_addr2", 32'(fq.imem_addr), 32'h0000);
        check_eq("wrap_pc0", 32'(fq.instr_pc), 32'hFFFE);
        step();
        #1;
        check_eq("wrap_pc1", 32'(fq.instr_pc), 32'hFFFF);
        check_eq("wrap_instr1", 32'(fq.instr), 32'h00FFFF);
        step();
        #1;
        check_eq("wrap_pc2", 32'(fq.instr_pc), 32'h0000);

        // Reset with a full queue outranks a simultaneous redirect
        do_reset(1'b0);
        for (int c = 1; c < 6; c++) step();
        #1;
        check_eq("full_valid", 32'(fq.instr_valid), 32'h1);
        step();
        rst = 1'b1;
        redirect = 1'b1;
        redirect_pc = 16'h0200;
        #1;
        check_eq("mid_rst_valid", 32'(fq.instr_valid), 32'h0);
        check_eq("mid_rst_req", 32'(fq.imem_req), 32'h0);
        step();
        rst = 1'b0;
        redirect = 1'b0;
        fq.instr_ready = 1'b1;
        #1;
        check_eq("post_rst_valid", 32'(fq.instr_valid), 32'h0);
        check_eq("post_rst_addr", 32'(fq.imem_addr), 32'h10);
        step();
        step();
        #1;
        check_eq("post_rst_pc", 32'(fq.instr_pc), 32'h10);

`ifdef FETCH_PERF_EN
        // Stall counter: valid from cycle 2, ready low through cycle 8
        do_reset(1'b0);
        check_eq("perf_zero", perf, 32'h0);
        step();
        step();
        #1;
        check_eq("perf_c2", perf, 32'h0);
        for (int c = 3; c < 10; c++) step();
        #1;
        check_eq("perf_seven", perf, 32'd7);
        fq.instr_ready = 1'b1;
        step();
        #1;
        check_eq("perf_hold", perf, 32'd7);
        step();
        #1;
        check_eq("perf_hold2", perf, 32'd7);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
